seq_pattern_tx: RTL and testbench
=================================

// Module: seq_pattern_tx
// PURPOSE
//  Serial pattern transmitter: the stimulus side of the more1010 Moore sequence detector.
//  Accepts a PAT_W-bit pattern and a repeat count over a valid/ready handshake.
//  Emits the pattern MSB-first, one bit per clk, repeated N times, with an optional idle gap between repeats.
//  Drives the detector's serial 'in' directly: on-chip traffic source and self-test generator.
// PARAMETERS
//  PAT_W     4  pattern width in bits (>=2)
//  CNT_W     8  repeat-count width
//  GAP_BITS  0  idle cycles between repeats (out=0, out_valid=0); 0 = back-to-back
// PORTS
//  clk          in   1      rising-edge clock; the only clock
//  reset        in   1      synchronous, active-low reset
//  start_valid  in   1      request to send; pattern and repeat_cnt are valid
//  start_ready  out  1      block can accept a request
//  pattern      in   PAT_W  bits to send, MSB first; captured on accept
//  repeat_cnt   in   CNT_W  number of repeats; captured on accept
//  abort        in   1      synchronous cancel of the current transfer
//  out          out  1      serial bit; drives the detector's in
//  out_valid    out  1      out carries a pattern bit this cycle
//  frame        out  1      high on the first bit of each repeat
//  busy         out  1      state != IDLE
//  done         out  1      1-cycle pulse, coincident with the final bit
// BEHAVIOUR
//  - Reset (reset==0 at a clk edge): state=IDLE; out, out_valid, frame, busy, done=0; regs cleared.
//  - Reset wins over every other input. Mid-transfer reset drops the transfer with no done.
//  - All outputs are registered Moore outputs, except start_ready = (state==IDLE) && !abort.
//  - Accept: start_valid && start_ready at an edge.
//    - Capture pattern into pat_q and repeat_cnt into rep_q.
//    - Load the shift register with pattern; bit_idx=PAT_W-1.
//  - Latency: first bit appears on out in the cycle after accept.
//  - States:
//    - IDLE: wait for accept. repeat_cnt!=0 -> SHIFT. repeat_cnt==0 -> ZERO.
//    - SHIFT: out=shreg[MSB], out_valid=1, frame=(bit_idx==PAT_W-1). Shift left each cycle.
//      - When bit_idx==0 and rep_q>1: decrement rep_q.
//        - GAP_BITS>0 -> GAP.
//        - GAP_BITS==0 -> reload from pat_q and stay in SHIFT (no bubble).
//      - When bit_idx==0 and rep_q==1: done=1 this cycle, next state IDLE.
//    - GAP: out=0, out_valid=0 for exactly GAP_BITS cycles; then reload from pat_q -> SHIFT.
//    - ZERO: one cycle, done=1, out_valid=0 -> IDLE. No bits are emitted.
//  - Back-to-back requests: the earliest next accept is the IDLE cycle after done.
//    - Gives a 1-cycle bubble (out=0, out_valid=0) between requests.
//  - abort: sampled every cycle.
//    - Non-IDLE: next state IDLE, outputs cleared, no done pulse.
//    - IDLE: blocks accept (start_ready=0).
//  - start_valid while busy: ignored, not queued. pattern and repeat_cnt may change freely after accept.
//  - rep_q counts down without wrap. Total bits emitted = PAT_W * repeat_cnt (max PAT_W*(2^CNT_W-1)).
//  - bit_idx width = $clog2(PAT_W). GAP counter width = $clog2(GAP_BITS+1), minimum 1.
// STRUCTURE
//  - Package seq_pkg:
//    - state enum {IDLE, SHIFT, GAP, ZERO}, 2-bit encoding.
//    - PATTERN_1010 = 4'b1010 constant, shared with more1010 benches.
//  - One sub-module, seq_tx_shreg: PAT_W-bit parallel-load, shift-left register.
//    - Inputs: load, shift, d. Output: msb.
//  - Top level holds the FSM, rep_q, bit_idx, the gap counter and the output registers.
// TESTING
//  1. pattern=4'b1010, repeat_cnt=1, GAP_BITS=0, accept at cycle 0:
//     out=1,0,1,0 on cycles 1-4; out_valid=1 on cycles 1-4; frame only on cycle 1; done only on cycle 4;
//     start_ready=1 again on cycle 5.
//  2. 4'b1010, repeat_cnt=3, GAP_BITS=0:
//     12 contiguous bits 101010101010; frame on cycles 1, 5, 9; done on cycle 12.
//     Looped into more1010 (overlapping detection): exactly 5 detections.
//  3. 4'b1010, repeat_cnt=2, GAP_BITS=2:
//     bits 1010 on cycles 1-4, out_valid=0 on cycles 5-6, 1010 on cycles 7-10; done on cycle 10.
//  4. repeat_cnt=0: no out_valid; done on cycle 1; busy on cycle 1 only.
//  5. abort on cycle 2 of a 1010 x2 transfer: out_valid=0 and busy=0 from cycle 3; no done.
//     Same-cycle abort+start_valid in IDLE: not accepted.
//  6. reset=0 on cycle 3 mid-transfer: all outputs 0 on cycle 4.
//     start_valid held during reset: not accepted. Accepted on the first edge with reset=1.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern transmitter and its more1010 benches.
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2,
      ZERO  = 2'd3
   } state_t;

   localparam logic [3:0] PATTERN_1010 = 4'b1010;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Request handshake, abort and serial output bundle of seq_pattern_tx.
interface seq_pattern_tx_if #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
);
   logic             start_valid;
   logic             start_ready;
   logic [PAT_W-1:0] pattern;
   logic [CNT_W-1:0] repeat_cnt;
   logic             abort;
   logic             out;
   logic             out_valid;
   logic             frame;
   logic             busy;
   logic             done;

   modport master (
      output start_valid, pattern, repeat_cnt, abort,
      input  start_ready, out, out_valid, frame, busy, done
   );

   modport slave (
      input  start_valid, pattern, repeat_cnt, abort,
      output start_ready, out, out_valid, frame, busy, done
   );
endinterface

// File: rtl/seq_tx_shreg.sv
// Parallel-load, shift-left register; zeros enter at the LSB so the MSB idles low once drained.
module seq_tx_shreg #(
   parameter int PAT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [PAT_W-1:0] d,
   output logic             msb
);

   logic [PAT_W-1:0] q;

   always_ff @(posedge clk) begin
      if (!reset)     q <= '0;
      else if (load)  q <= d;
      else if (shift) q <= {q[PAT_W-2:0], 1'b0};
   end

   assign msb = q[PAT_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends an accepted pattern MSB-first, repeat_cnt times, with optional idle gaps.
module seq_pattern_tx
   import seq_pkg::*;
#(
   parameter int PAT_W    = 4,
   parameter int CNT_W    = 8,
   parameter int GAP_BITS = 0
) (
   input  logic             clk,
   input  logic             reset,
   seq_pattern_tx_if.slave  bus
);

   localparam int IW = $clog2(PAT_W);
   localparam int GW = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
   localparam logic [IW-1:0]    IDX_LAST = IW'(PAT_W - 1);
   localparam logic [GW-1:0]    GAP_LAST = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
   localparam logic [CNT_W-1:0] REP_ONE  = CNT_W'(1);

   state_t           state_q, state_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [CNT_W-1:0] rep_q, rep_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic             sh_load, sh_shift, sh_msb;
   logic [PAT_W-1:0] sh_d;
   logic             start_ready;
   logic             out_valid_q, frame_q, busy_q, done_q;
   logic             out_valid_d, frame_d, busy_d, done_d;

   assign start_ready = (state_q == IDLE) && !bus.abort;

   seq_tx_shreg #(.PAT_W(PAT_W)) u_shreg (
      .clk   (clk),
      .reset (reset),
      .load  (sh_load),
      .shift (sh_shift),
      .d     (sh_d),
      .msb   (sh_msb)
   );

   always_comb begin
      state_d  = state_q;
      pat_d    = pat_q;
      rep_d    = rep_q;
      idx_d    = idx_q;
      gap_d    = gap_q;
      sh_load  = 1'b0;
      sh_shift = 1'b0;
      sh_d     = pat_q;
      case (state_q)
         IDLE: begin
            if (bus.start_valid && start_ready) begin
               pat_d = bus.pattern;
               rep_d = bus.repeat_cnt;
               if (bus.repeat_cnt != '0) begin
                  state_d = SHIFT;
                  sh_load = 1'b1;
                  sh_d    = bus.pattern;
                  idx_d   = IDX_LAST;
               end else begin
                  state_d = ZERO;
               end
            end
         end
         SHIFT: begin
            sh_shift = 1'b1;
            if (idx_q != '0) begin
               idx_d = idx_q - 1'b1;
            end else if (rep_q > REP_ONE) begin
               rep_d = rep_q - 1'b1;
               if (GAP_BITS > 0) begin
                  state_d = GAP;
                  gap_d   = GAP_LAST;
               end else begin
                  sh_load = 1'b1;
                  idx_d   = IDX_LAST;
               end
            end else begin
               state_d = IDLE;
            end
         end
         GAP: begin
            if (gap_q != '0) begin
               gap_d = gap_q - 1'b1;
            end else begin
               state_d = SHIFT;
               sh_load = 1'b1;
               idx_d   = IDX_LAST;
            end
         end
         ZERO:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Abort also zero-loads the shift register so out drops on the next cycle.
      if (bus.abort && (state_q != IDLE)) begin
         state_d  = IDLE;
         sh_load  = 1'b1;
         sh_shift = 1'b0;
         sh_d     = '0;
      end
      out_valid_d = (state_d == SHIFT);
      frame_d     = (state_d == SHIFT) && (idx_d == IDX_LAST);
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == ZERO) ||
                    ((state_d == SHIFT) && (idx_d == '0) && (rep_d == REP_ONE));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         pat_q       <= '0;
         rep_q       <= '0;
         idx_q       <= '0;
         gap_q       <= '0;
         out_valid_q <= 1'b0;
         frame_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pat_q       <= pat_d;
         rep_q       <= rep_d;
         idx_q       <= idx_d;
         gap_q       <= gap_d;
         out_valid_q <= out_valid_d;
         frame_q     <= frame_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.start_ready = start_ready;
   assign bus.out         = sh_msb;
   assign bus.out_valid   = out_valid_q;
   assign bus.frame       = frame_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Drives a back-to-back instance and a 2-cycle-gap instance with shared stimulus against a per-cycle output-queue model.
module tb_seq_pattern_tx;
   import seq_pkg::*;

   localparam int GAP0 = 0;
   localparam int GAP1 = 2;

   typedef struct packed {
      logic o;
      logic v;
      logic f;
      logic dn;
      logic b;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_valid;
   logic [3:0] pattern;
   logic [7:0] repeat_cnt;
   logic       abort;

   int   checks = 0;
   int   errors = 0;
   bit   inited = 1'b0;
   exp_t mem [2][0:2047];
   int   rd [2];
   int   wr [2];
   exp_t cur [2];
   logic [3:0] hist;
   int   det;

   always #5 clk = ~clk;

   seq_pattern_tx_if #(.PAT_W(4), .CNT_W(8)) if0 ();
   seq_pattern_tx_if #(.PAT_W(4), .CNT_W(8)) if1 ();

   assign if0.start_valid = start_valid;
   assign if0.pattern     = pattern;
   assign if0.repeat_cnt  = repeat_cnt;
   assign if0.abort       = abort;
   assign if1.start_valid = start_valid;
   assign if1.pattern     = pattern;
   assign if1.repeat_cnt  = repeat_cnt;
   assign if1.abort       = abort;

   seq_pattern_tx #(.PAT_W(4), .CNT_W(8), .GAP_BITS(GAP0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
   seq_pattern_tx #(.PAT_W(4), .CNT_W(8), .GAP_BITS(GAP1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic push(input int d, input exp_t e);
      mem[d][wr[d]] = e;
      wr[d]++;
   endtask

   // Expected output tuple for every cycle of one request, straight from the transfer rules.
   task automatic build(input int d, input logic [3:0] pat, input int cnt);
      int gap;
      gap   = (d == 0) ? GAP0 : GAP1;
      rd[d] = 0;
      wr[d] = 0;
      if (cnt == 0) begin
         push(d, exp_t'{o: 1'b0, v: 1'b0, f: 1'b0, dn: 1'b1, b: 1'b1});
      end else begin
         for (int r = 0; r < cnt; r++) begin
            for (int i = 0; i < 4; i++) begin
               push(d, exp_t'{o: pat[2'(3 - i)], v: 1'b1, f: (i == 0),
                              dn: (r == cnt - 1) && (i == 3), b: 1'b1});
            end
            if (r < cnt - 1)
               for (int g = 0; g < gap; g++)
                  push(d, exp_t'{o: 1'b0, v: 1'b0, f: 1'b0, dn: 1'b0, b: 1'b1});
         end
      end
   endtask

   task automatic model_step(input int d, input logic sv, input logic [3:0] pat,
                             input logic [7:0] cnt, input logic ab, input logic rs);
      if (!rs || (ab && cur[d].b)) begin
         rd[d]  = 0;
         wr[d]  = 0;
         cur[d] = '0;
      end else if (!cur[d].b && sv && !ab) begin
         build(d, pat, int'(cnt));
         cur[d] = mem[d][rd[d]];
         rd[d]++;
      end else if (rd[d] < wr[d]) begin
         cur[d] = mem[d][rd[d]];
         rd[d]++;
      end else begin
         cur[d] = '0;
      end
   endtask

   task automatic cycle(input logic sv, input logic [3:0] pat, input logic [7:0] cnt,
                        input logic ab, input logic rs);
      start_valid = sv;
      pattern     = pat;
      repeat_cnt  = cnt;
      abort       = ab;
      reset       = rs;
      #1;
      if (inited) begin
         chk("g0.start_ready", 16'(if0.start_ready), 16'(!cur[0].b && !ab));
         chk("g2.start_ready", 16'(if1.start_ready), 16'(!cur[1].b && !ab));
      end
      @(posedge clk);
      model_step(0, sv, pat, cnt, ab, rs);
      model_step(1, sv, pat, cnt, ab, rs);
      if (!rs) inited = 1'b1;
      @(negedge clk);
      chk("g0.out",       16'(if0.out),       16'(cur[0].o));
      chk("g0.out_valid", 16'(if0.out_valid), 16'(cur[0].v));
      chk("g0.frame",     16'(if0.frame),     16'(cur[0].f));
      chk("g0.done",      16'(if0.done),      16'(cur[0].dn));
      chk("g0.busy",      16'(if0.busy),      16'(cur[0].b));
      chk("g2.out",       16'(if1.out),       16'(cur[1].o));
      chk("g2.out_valid", 16'(if1.out_valid), 16'(cur[1].v));
      chk("g2.frame",     16'(if1.frame),     16'(cur[1].f));
      chk("g2.done",      16'(if1.done),      16'(cur[1].dn));
      chk("g2.busy",      16'(if1.busy),      16'(cur[1].b));
      hist = {hist[2:0], if0.out};
      if (hist == 4'b1010) det++;
   endtask

   // Idle until both instances are back in IDLE, with scrambled request fields to show they are ignored.
   task automatic drain();
      int n;
      n = 0;
      while ((cur[0].b || cur[1].b) && n < 3000) begin
         cycle(1'b0, 4'($urandom), 8'($urandom), 1'b0, 1'b1);
         n++;
      end
      chk("drain_bound", 16'(n < 3000), 16'(1));
      cycle(1'b0, 4'($urandom), 8'($urandom), 1'b0, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      rd   = '{0, 0};
      wr   = '{0, 0};
      cur  = '{'0, '0};
      hist = '0;
      det  = 0;

      // Request held through reset is taken on the first edge with reset released.
      repeat (3) cycle(1'b1, PATTERN_1010, 8'd1, 1'b0, 1'b0);
      cycle(1'b1, PATTERN_1010, 8'd1, 1'b0, 1'b1);
      drain();

      cycle(1'b1, PATTERN_1010, 8'd1, 1'b0, 1'b1);
      drain();

      hist = '0;
      det  = 0;
      cycle(1'b1, PATTERN_1010, 8'd3, 1'b0, 1'b1);
      drain();
      chk("g0.overlap_1010_count", 16'(det), 16'(5));

      cycle(1'b1, PATTERN_1010, 8'd2, 1'b0, 1'b1);
      drain();

      cycle(1'b1, 4'($urandom), 8'd0, 1'b0, 1'b1);
      drain();

      cycle(1'b1, PATTERN_1010, 8'd2, 1'b0, 1'b1);
      cycle(1'b0, PATTERN_1010, 8'd2, 1'b0, 1'b1);
      cycle(1'b0, PATTERN_1010, 8'd2, 1'b1, 1'b1);
      drain();
      cycle(1'b1, PATTERN_1010, 8'd1, 1'b1, 1'b1);
      cycle(1'b0, PATTERN_1010, 8'd1, 1'b0, 1'b1);
      drain();

      cycle(1'b1, PATTERN_1010, 8'd2, 1'b0, 1'b1);
      cycle(1'b0, PATTERN_1010, 8'd2, 1'b0, 1'b1);
      cycle(1'b0, PATTERN_1010, 8'd2, 1'b0, 1'b1);
      cycle(1'b1, 4'b0110, 8'd1, 1'b0, 1'b0);
      cycle(1'b1, 4'b0110, 8'd1, 1'b0, 1'b1);
      drain();

      cycle(1'b1, 4'($urandom), 8'd255, 1'b0, 1'b1);
      drain();

      for (int k = 0; k < 800; k++) begin
         cycle($urandom_range(0, 99) < 40, 4'($urandom), 8'($urandom_range(0, 6)),
               $urandom_range(0, 99) < 4, !($urandom_range(0, 99) < 2));
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
